// File: rtl/mc_control.sv
// Multicycle MIPS main controller: a Moore FSM that sequences the shared datapath
// (PC, IR, register file, ALU, unified memory) through fetch/decode/execute/memory/
// writeback steps and drives every datapath select and write strobe.
// Optional build macro: MC_CONTROL_ILLEGAL_TRAP_EN adds the illegal_op output and a
// TRAP state that is left only via rst. Without it, unknown opcodes retire as NOPs.
module mc_control #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       mem_timeout,
  output logic [3:0] state
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11,
    StTrap   = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [3:0] WaitMax = 4'(MEM_WAIT_MAX);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  // Set once a wait has timed out so the saturated counter pulses only once.
  logic       timed_out_q, timed_out_d;
  logic       wait_st;
  logic       timeout_hit;
  logic       op_known;

  assign state = state_q;

  assign op_known = (op == OpRtype) || (op == OpLw) || (op == OpSw) ||
                    (op == OpBeq) || (op == OpAddi) || (op == OpJ);

  assign wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

  assign timeout_hit = wait_st && !mem_ready && (wait_cnt_q == WaitMax) && !timed_out_q;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpRtype:     state_d = StExec;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq:       state_d = StBranch;
          OpAddi:      state_d = StAddiEx;
          OpJ:         state_d = StJump;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
          default:     state_d = StTrap;
`else
          default:     state_d = StFetch;
`endif
        endcase
      end
      StMemAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StJump:   state_d = StFetch;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      StTrap:   state_d = StTrap;
`endif
      default:  state_d = StFetch;
    endcase
  end

  // Memory-wait counter: counts stalled cycles, saturates, clears on ready or state change.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    timed_out_d = timed_out_q;
    if (mem_ready || (state_d != state_q) || !wait_st) begin
      wait_cnt_d  = 4'd0;
      timed_out_d = 1'b0;
    end else if (wait_cnt_q == WaitMax) begin
      timed_out_d = 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // State and wait-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      wait_cnt_q  <= 4'd0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Datapath controls decoded from the current state; reset forces FETCH selects, no strobes.
  always_comb begin
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_src      = 2'b00;
    instr_done  = 1'b0;
    mem_timeout = timeout_hit;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    illegal_op  = 1'b0;
`endif
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        alu_src_b = 2'b11;
`ifndef MC_CONTROL_ILLEGAL_TRAP_EN
        // Unknown opcodes retire here as a NOP.
        instr_done = !op_known;
`endif
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StAddiWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StJump: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      StTrap: illegal_op = 1'b1;
`endif
      default: ;
    endcase
    if (rst) begin
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b01;
      alu_op      = 2'b00;
      pc_src      = 2'b00;
      instr_done  = 1'b0;
      mem_timeout = 1'b0;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      illegal_op  = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control in its default build (illegal-op trap disabled).
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       iord, mem_read, mem_write, ir_write, pc_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, instr_done, mem_timeout;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;
  int unsigned n_failed = 0;
  int          n_done;
  int          n_to;
  int          to_idx;

  mc_control #(.MEM_WAIT_MAX(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .pc_src      (pc_src),
    .instr_done  (instr_done),
    .mem_timeout (mem_timeout),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else begin
      n_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, drive inputs, let combinational outputs settle.
  task automatic cyc(input logic r, input logic mr, input logic [5:0] o, input logic z);
    @(negedge clk);
    rst       = r;
    mem_ready = mr;
    op        = o;
    zero      = z;
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; op = 6'b000000; zero = 1'b0;

    // Reset, two cycles
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 6'b000000, 1'b0);
      chk("rst_state", state, 4'd0);
      chk("rst_strobes", {mem_read, mem_write, ir_write, pc_write, reg_write, instr_done,
                          mem_timeout}, 7'b0);
      chk("rst_sel", {iord, alu_src_a, alu_src_b, alu_op, pc_src}, 8'b0_0_01_00_00);
    end

    // R-type, mem_ready tied high: 0,1,6,7
    n_done = 0;
    cyc(1'b0, 1'b1, 6'b000000, 1'b0);
    chk("r_fetch_state", state, 4'd0);
    chk("r_fetch_strb", {mem_read, ir_write, pc_write, alu_src_b}, 5'b111_01);
    n_done += int'(instr_done);
    cyc(1'b0, 1'b1, 6'b000000, 1'b0);
    chk("r_decode", {state, alu_src_b}, {4'd1, 2'b11});
    n_done += int'(instr_done);
    cyc(1'b0, 1'b1, 6'b000000, 1'b0);
    chk("r_exec", {state, alu_src_a, alu_op, reg_write}, {4'd6, 1'b1, 2'b10, 1'b0});
    n_done += int'(instr_done);
    cyc(1'b0, 1'b1, 6'b000000, 1'b0);
    chk("r_aluwb", {state, reg_write, reg_dst, mem_to_reg}, {4'd7, 3'b110});
    n_done += int'(instr_done);
    chk("r_done_once", n_done, 1);

    // lw with three stalled cycles in MEMRD: 0,1,2,3,3,3,3,4
    cyc(1'b0, 1'b1, 6'b100011, 1'b0);
    chk("lw_fetch", state, 4'd0);
    cyc(1'b0, 1'b1, 6'b100011, 1'b0);
    chk("lw_decode", state, 4'd1);
    cyc(1'b0, 1'b1, 6'b100011, 1'b0);
    chk("lw_memadr", {state, alu_src_a, alu_src_b}, {4'd2, 1'b1, 2'b10});
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, (i == 3), 6'b100011, 1'b0);
      chk("lw_memrd", {state, mem_read, iord, instr_done}, {4'd3, 3'b110});
    end
    cyc(1'b0, 1'b1, 6'b100011, 1'b0);
    chk("lw_memwb", {state, reg_write, mem_to_reg, reg_dst, instr_done}, {4'd4, 4'b1101});

    // sw: 0,1,2,5
    cyc(1'b0, 1'b1, 6'b101011, 1'b0);
    chk("sw_fetch", state, 4'd0);
    cyc(1'b0, 1'b1, 6'b101011, 1'b0);
    cyc(1'b0, 1'b1, 6'b101011, 1'b0);
    chk("sw_memadr", state, 4'd2);
    cyc(1'b0, 1'b1, 6'b101011, 1'b0);
    chk("sw_memwr", {state, mem_write, iord, instr_done, mem_read}, {4'd5, 4'b1110});

    // beq taken then not taken
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b1, 6'b000100, (k == 0));
      chk("beq_fetch", state, 4'd0);
      cyc(1'b0, 1'b1, 6'b000100, (k == 0));
      cyc(1'b0, 1'b1, 6'b000100, (k == 0));
      chk("beq_branch", {state, alu_src_a, alu_op, pc_src, instr_done},
          {4'd8, 1'b1, 2'b01, 2'b01, 1'b1});
      chk("beq_pcw", pc_write, (k == 0));
    end

    // addi: 0,1,9,10
    cyc(1'b0, 1'b1, 6'b001000, 1'b0);
    cyc(1'b0, 1'b1, 6'b001000, 1'b0);
    cyc(1'b0, 1'b1, 6'b001000, 1'b0);
    chk("addi_ex", {state, alu_src_a, alu_src_b}, {4'd9, 1'b1, 2'b10});
    cyc(1'b0, 1'b1, 6'b001000, 1'b0);
    chk("addi_wb", {state, reg_write, reg_dst, instr_done}, {4'd10, 3'b101});

    // j: 0,1,11
    cyc(1'b0, 1'b1, 6'b000010, 1'b0);
    cyc(1'b0, 1'b1, 6'b000010, 1'b0);
    cyc(1'b0, 1'b1, 6'b000010, 1'b0);
    chk("j_jump", {state, pc_src, pc_write, instr_done}, {4'd11, 2'b10, 2'b11});

    // 20 stalled FETCH cycles: one timeout pulse, on the 16th stalled cycle
    n_to = 0; to_idx = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 6'b111111, 1'b0);
      chk("to_state", {state, ir_write, pc_write, mem_read}, {4'd0, 3'b001});
      if (mem_timeout) begin
        n_to++;
        to_idx = i;
      end
    end
    chk("to_count", n_to, 1);
    chk("to_index", to_idx, 15);
    cyc(1'b0, 1'b1, 6'b111111, 1'b0);
    chk("to_release", {state, ir_write, mem_timeout}, {4'd0, 2'b10});

    // Illegal opcode retires as NOP in DECODE
    cyc(1'b0, 1'b1, 6'b111111, 1'b0);
    chk("ill_decode", {state, instr_done}, {4'd1, 1'b1});
    cyc(1'b0, 1'b1, 6'b111111, 1'b0);
    chk("ill_back", state, 4'd0);

    // Reset in the middle of an R-type
    cyc(1'b0, 1'b1, 6'b000000, 1'b0);
    chk("mid_decode", state, 4'd1);
    cyc(1'b1, 1'b1, 6'b000000, 1'b0);
    chk("mid_rst_strb", {mem_read, mem_write, ir_write, pc_write, reg_write, instr_done,
                         alu_src_a, alu_op}, 10'b0);
    cyc(1'b0, 1'b1, 6'b000000, 1'b0);
    chk("mid_restart", {state, mem_read, ir_write}, {4'd0, 2'b11});

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle MIPS main controller: a Moore FSM that sequences the shared datapath (PC, IR, register file, single ALU, unified memory) through fetch/decode/execute/memory/writeback steps.
- Consumes the 6-bit opcode from the IR and a memory-ready handshake.
- Drives all datapath mux selects and write strobes.
- Sits between the instruction decoder and the datapath in the CPU top level.

Parameters:
- MEM_WAIT_MAX, 15, max cycles waited on mem_ready before mem_timeout pulses (counter width 4 bits)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  opcode field IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- iord  out  1  0=PC addresses memory, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- pc_write  out  1  load PC (unconditional or taken beq)
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded
- pc_src  out  2  00=ALU, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- mem_timeout  out  1  one-cycle pulse when a wait exceeds MEM_WAIT_MAX
- state  out  4  current state encoding, for debug

Behaviour:
- State register updates on the rising edge of clk. rst=1 at an edge sets state=FETCH (0) and wait_cnt=0.
- Outputs are combinational from the state (plus zero and mem_ready where noted). While rst=1, all strobes (mem_read, mem_write, ir_write, pc_write, reg_write, instr_done, mem_timeout) are forced to 0. All selects then take FETCH values: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
- Default for every output in every state is 0 unless listed below.
- FETCH(0):
  - mem_read=1, alu_src_b=01.
  - ir_write and pc_write are 1 only in cycles where mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE(1): alu_src_b=11 (branch target precompute). Next state by op:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other op → ILLEGAL handling (see Optional Feature)
- MEMADR(2): alu_src_a=1, alu_src_b=10. Next state is MEMRD if op=100011, else MEMWR.
- MEMRD(3): mem_read=1, iord=1. Stay while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEMWR(5): mem_write=1, iord=1. Stay while mem_ready=0. When mem_ready=1: instr_done=1, next state FETCH.
- EXEC(6): alu_src_a=1, alu_op=10. Next state ALUWB.
- ALUWB(7): reg_write=1, reg_dst=1, instr_done=1. Next state FETCH.
- BRANCH(8): alu_src_a=1, alu_op=01, pc_src=01, pc_write=zero, instr_done=1. Next state FETCH.
- ADDIEX(9): alu_src_a=1, alu_src_b=10. Next state ADDIWB.
- ADDIWB(10): reg_write=1, reg_dst=0, instr_done=1. Next state FETCH.
- JUMP(11): pc_src=10, pc_write=1, instr_done=1. Next state FETCH.
- Wait counter (wait_cnt):
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - When wait_cnt==MEM_WAIT_MAX with mem_ready=0, mem_timeout pulses for 1 cycle and wait_cnt saturates. The FSM keeps waiting.
- Unused encodings 12–15 return to FETCH on the next edge, with all strobes 0.
- A reset asserted mid-instruction aborts it. No strobe is issued in the reset cycle, and the FSM restarts at FETCH.
- Latencies, assuming mem_ready=1 on the first request:
  - R-type 4 cycles
  - lw 5 cycles
  - sw 4 cycles
  - beq 3 cycles
  - addi 4 cycles
  - j 3 cycles

Optional Feature:
- Macro: MC_CONTROL_ILLEGAL_TRAP_EN
- Defined:
  - Adds output illegal_op (1 bit) and state TRAP(12).
  - An unknown op in DECODE goes to TRAP.
  - TRAP holds illegal_op=1, issues no strobes, and is left only via rst.
- Undefined:
  - An unknown op in DECODE is treated as a NOP: the next state is FETCH and instr_done=1 in the DECODE cycle.
  - Port illegal_op is absent.

Test Plan:
- rst=1 for 2 cycles, then released with mem_ready=1 → state=0 and all strobes 0 during reset; the first cycle after release gives mem_read=1, ir_write=1, pc_write=1.
- op=000000 R-type with mem_ready tied 1 → states 0,1,6,7,0; reg_write=1 with reg_dst=1 in cycle 4; instr_done pulses once.
- op=100011 lw, mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles; MEMWB asserts reg_write=1 and mem_to_reg=1; total 8 cycles.
- op=000100 beq, zero=1 then a repeat with zero=0 → pc_write=1 with pc_src=01 in BRANCH for the first run; pc_write=0 for the second.
- mem_ready held 0 in FETCH for 20 cycles, MEM_WAIT_MAX=15 → exactly one mem_timeout pulse, state stays 0, and the FSM proceeds once mem_ready=1.
- op=111111 → with MC_CONTROL_ILLEGAL_TRAP_EN: state=12, illegal_op=1 held until rst. Without it: returns to FETCH after DECODE with an instr_done pulse.
